// File: rtl/frame_swap_scheduler.sv
// Frame sequencer for the double-buffered pixel BRAM pair: raster-orders renderer
// pixels into buffer writes and swaps buffers on the first vsync after a frame completes.
module frame_swap_scheduler #(
  parameter int WIDTH    = 12,
  parameter int H_PIX    = 320,
  parameter int V_PIX    = 240,
  parameter int ADDR_LEN = 17,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync_pulse_i,
  input  logic                px_valid_i,
  input  logic [WIDTH-1:0]    px_data_i,
  output logic                px_ready_o,
  output logic                frame_start_o,
  output logic                write_enable_o,
  output logic [ADDR_LEN-1:0] write_addr_o,
  output logic [WIDTH-1:0]    write_data_o,
  output logic                swap_buffers_o,
  output logic                frame_done_o,
  output logic [CNT_BITS-1:0] late_frames_o,
  output logic [1:0]          state_o
);

  // Handshake: a pixel transfers on every cycle where px_valid_i && px_ready_o;
  // px_ready_o depends only on state, and the renderer must hold px_data_i while not ready.

  // state_o encoding: 0 = IDLE, 1 = RENDER, 2 = WAIT_VSYNC.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RENDER     = 2'd1,
    WAIT_VSYNC = 2'd2
  } state_t;

  localparam logic [ADDR_LEN-1:0] LAST_PIX = ADDR_LEN'(H_PIX * V_PIX - 1);

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                swap_q, swap_d;
  logic                fs_q, fs_d;
  logic [CNT_BITS-1:0] late_q, late_d;
  logic                accept;

  assign accept = (state_q == RENDER) && px_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      swap_q  <= 1'b0;
      fs_q    <= 1'b0;
      late_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      swap_q  <= swap_d;
      fs_q    <= fs_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    swap_d  = 1'b0;
    fs_d    = 1'b0;
    late_d  = late_q;

    case (state_q)
      IDLE: begin
        // The first frame after reset fills the post-reset write buffer; no swap.
        state_d = RENDER;
        fs_d    = 1'b1;
      end
      RENDER: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = px_data_i;
          if (cnt_q == LAST_PIX) begin
            cnt_d   = '0;
            state_d = WAIT_VSYNC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_VSYNC: begin
        if (vsync_pulse_i) begin
          swap_d  = 1'b1;
          fs_d    = 1'b1;
          state_d = RENDER;
        end
      end
      default: state_d = IDLE;
    endcase

    // A vsync that finds the frame still rendering is a missed display frame.
    if (vsync_pulse_i && (state_q != WAIT_VSYNC) && (late_q != {CNT_BITS{1'b1}})) begin
      late_d = late_q + 1'b1;
    end
  end

  assign px_ready_o     = (state_q == RENDER);
  assign frame_done_o   = (state_q == WAIT_VSYNC);
  assign frame_start_o  = fs_q;
  assign write_enable_o = we_q;
  assign write_addr_o   = addr_q;
  assign write_data_o   = data_q;
  assign swap_buffers_o = swap_q;
  assign late_frames_o  = late_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Self-checking bench for frame_swap_scheduler on a 4x2 frame, with a pixel-count
// reference model and a write scoreboard.
module tb_frame_swap_scheduler;

  localparam int WIDTH    = 12;
  localparam int H_PIX    = 4;
  localparam int V_PIX    = 2;
  localparam int ADDR_LEN = 17;
  localparam int CNT_BITS = 8;
  localparam int FRAME    = H_PIX * V_PIX;
  localparam int MAX_LATE = (1 << CNT_BITS) - 1;
  localparam int W        = ADDR_LEN + WIDTH;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                vsync = 1'b0;
  logic                pv = 1'b0;
  logic [WIDTH-1:0]    pd = '0;
  logic                px_ready, fs, we, swap, done;
  logic [ADDR_LEN-1:0] waddr;
  logic [WIDTH-1:0]    wdata;
  logic [CNT_BITS-1:0] late;
  logic [1:0]          dbg_state;

  int checks = 0;
  int failures = 0;

  frame_swap_scheduler #(
    .WIDTH(WIDTH), .H_PIX(H_PIX), .V_PIX(V_PIX), .ADDR_LEN(ADDR_LEN), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .vsync_pulse_i(vsync), .px_valid_i(pv), .px_data_i(pd),
    .px_ready_o(px_ready), .frame_start_o(fs), .write_enable_o(we), .write_addr_o(waddr),
    .write_data_o(wdata), .swap_buffers_o(swap), .frame_done_o(done),
    .late_frames_o(late), .state_o(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Tracks pixels accepted in the current frame; a frame with FRAME pixels waits for vsync.
  bit          m_started;
  int          m_pixels;
  int          m_late;
  logic        exp_fs, exp_swap, exp_we;
  logic [W-1:0] exp_wr;
  logic [W-1:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_started = 0; m_pixels = 0; m_late = 0;
      exp_fs = 0; exp_swap = 0; exp_we = 0; exp_wr = '0;
      exp_q.delete();
    end else begin
      bit waiting;
      waiting = m_started && (m_pixels == FRAME);
      exp_fs = 0; exp_swap = 0; exp_we = 0;
      if (vsync && !waiting) m_late = (m_late + 1 > MAX_LATE) ? MAX_LATE : m_late + 1;
      if (!m_started) begin
        m_started = 1;
        exp_fs = 1;
      end else if (!waiting && pv) begin
        exp_we = 1;
        exp_wr = {ADDR_LEN'(m_pixels), pd};
        exp_q.push_back(exp_wr);
        m_pixels++;
      end else if (waiting && vsync) begin
        exp_swap = 1;
        exp_fs = 1;
        m_pixels = 0;
      end
    end
  end

  function automatic logic exp_ready();
    return m_started && (m_pixels < FRAME);
  endfunction

  function automatic logic exp_done();
    return m_started && (m_pixels == FRAME);
  endfunction

  // ---------------- driver ----------------
  // Advance one cycle; outputs are sampled on the falling edge. Pops the scoreboard on a write.
  task automatic tick(output logic [W-1:0] sb);
    @(posedge clk);
    @(negedge clk);
    sb = 'x;
    if (we === 1'b1 && exp_q.size() != 0) sb = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] sb;
    rst = 1; pv = 0; vsync = 0;
    for (int i = 0; i < 3; i++) begin
      tick(sb);
      checks++;
      if ({fs, we, swap, px_ready, done} !== 5'b0 || waddr !== '0 || wdata !== '0 || late !== '0) begin
        failures++;
        $display("FAIL reset_outputs: fs=%b we=%b swap=%b rdy=%b done=%b addr=%0d data=%h late=%0d, required all 0",
                 fs, we, swap, px_ready, done, waddr, wdata, late);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
        failures++;
        $display("FAIL reset_state: state=%0d, required 0", dbg_state);
      end
    end
    rst = 0;
    tick(sb);
    checks++;
    if (fs !== 1'b1 || px_ready !== 1'b1 || swap !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: fs=%b rdy=%b swap=%b, required fs=1 rdy=1 swap=0", fs, px_ready, swap);
    end
    tick(sb);
    checks++;
    if (fs !== 1'b0 || px_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fs_single: fs=%b rdy=%b, required fs=0 rdy=1", fs, px_ready);
    end
  endtask

  task automatic test_full_frame();
    logic [W-1:0] sb;
    for (int i = 0; i < FRAME; i++) begin
      pv = 1; pd = WIDTH'(i + 1);
      tick(sb);
      checks++;
      if (we !== 1'b1 || waddr !== ADDR_LEN'(i) || wdata !== WIDTH'(i + 1)) begin
        failures++;
        $display("FAIL full_frame_write%0d: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                 i, we, waddr, wdata, i, i + 1);
      end
      checks++;
      if ({waddr, wdata} !== sb) begin
        failures++;
        $display("FAIL full_frame_sb%0d: got %h, required %h", i, {waddr, wdata}, sb);
      end
      checks++;
      if (px_ready !== (i < FRAME - 1) || done !== (i == FRAME - 1)) begin
        failures++;
        $display("FAIL full_frame_ready%0d: rdy=%b done=%b, required rdy=%b done=%b",
                 i, px_ready, done, i < FRAME - 1, i == FRAME - 1);
      end
    end
    pd = 12'h0AA;
  endtask

  task automatic test_vsync_swap();
    logic [W-1:0] sb;
    for (int i = 0; i < 3; i++) begin
      tick(sb);
      checks++;
      if (swap !== 1'b0 || done !== 1'b1 || px_ready !== 1'b0 || we !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold%0d: swap=%b done=%b rdy=%b we=%b, required 0 1 0 0", i, swap, done, px_ready, we);
      end
    end
    vsync = 1;
    tick(sb);
    vsync = 0;
    checks++;
    if (swap !== 1'b1 || fs !== 1'b1 || px_ready !== 1'b1 || we !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL swap_pulse: swap=%b fs=%b rdy=%b we=%b done=%b, required 1 1 1 0 0", swap, fs, px_ready, we, done);
    end
    tick(sb);
    checks++;
    if (swap !== 1'b0 || fs !== 1'b0 || we !== 1'b1 || waddr !== '0 || wdata !== 12'h0AA) begin
      failures++;
      $display("FAIL swap_first_write: swap=%b fs=%b we=%b addr=%0d data=%h, required 0 0 1 0 0aa",
               swap, fs, we, waddr, wdata);
    end
    checks++;
    if ({waddr, wdata} !== sb) begin
      failures++;
      $display("FAIL swap_first_sb: got %h, required %h", {waddr, wdata}, sb);
    end
    pv = 0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sb;
    int next_addr;
    next_addr = 1;
    for (int c = 0; c < 2 * (FRAME - 1); c++) begin
      pv = (c % 2 == 0); pd = WIDTH'($urandom);
      tick(sb);
      checks++;
      if (we !== (c % 2 == 0)) begin
        failures++;
        $display("FAIL backpressure_we%0d: we=%b, required %b", c, we, c % 2 == 0);
      end
      if (c % 2 == 0) begin
        checks++;
        if (waddr !== ADDR_LEN'(next_addr) || {waddr, wdata} !== sb) begin
          failures++;
          $display("FAIL backpressure_addr%0d: addr=%0d data=%h, required addr=%0d entry=%h",
                   c, waddr, wdata, next_addr, sb);
        end
        next_addr++;
      end
    end
    pv = 0;
    tick(sb);
    checks++;
    if (done !== 1'b1 || px_ready !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_done: done=%b rdy=%b, required done=1 rdy=0", done, px_ready);
    end
  endtask

  task automatic test_late_vsync();
    logic [W-1:0] sb;
    logic any_swap;
    vsync = 1; tick(sb); vsync = 0;
    checks++;
    if (swap !== 1'b1 || late !== 8'd0) begin
      failures++;
      $display("FAIL late_prep_swap: swap=%b late=%0d, required swap=1 late=0", swap, late);
    end
    for (int i = 0; i < 3; i++) begin
      pv = 1; pd = WIDTH'(12'h100 + i); tick(sb);
    end
    pv = 0; vsync = 1; tick(sb); vsync = 0;
    checks++;
    if (late !== 8'd1 || swap !== 1'b0) begin
      failures++;
      $display("FAIL late_in_render: late=%0d swap=%b, required late=1 swap=0", late, swap);
    end
    for (int i = 3; i < FRAME; i++) begin
      pv = 1; pd = WIDTH'(12'h100 + i);
      vsync = (i == FRAME - 1);
      tick(sb);
    end
    pv = 0; vsync = 0;
    checks++;
    if (late !== 8'd2 || swap !== 1'b0 || done !== 1'b1 || px_ready !== 1'b0) begin
      failures++;
      $display("FAIL late_last_accept: late=%0d swap=%b done=%b rdy=%b, required 2 0 1 0", late, swap, done, px_ready);
    end
    tick(sb);
    checks++;
    if (swap !== 1'b0) begin
      failures++;
      $display("FAIL late_no_swap: swap=%b, required 0", swap);
    end
    vsync = 1; tick(sb); vsync = 0;
    checks++;
    if (swap !== 1'b1 || late !== 8'd2) begin
      failures++;
      $display("FAIL late_next_swap: swap=%b late=%0d, required swap=1 late=2", swap, late);
    end
    any_swap = 0;
    for (int k = 0; k < 300; k++) begin
      vsync = 1; tick(sb); any_swap |= swap;
      vsync = 0; tick(sb); any_swap |= swap;
    end
    checks++;
    if (late !== 8'd255 || late !== CNT_BITS'(m_late) || any_swap !== 1'b0) begin
      failures++;
      $display("FAIL late_saturate: late=%0d any_swap=%b, required late=255 (model %0d) any_swap=0",
               late, any_swap, m_late);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] sb;
    logic prev_fs, prev_swap, prev_vs;
    rst = 1; pv = 0; vsync = 0;
    tick(sb); tick(sb);
    rst = 0;
    prev_fs = 0; prev_swap = 0; prev_vs = 0;
    for (int c = 0; c < 600; c++) begin
      pv = ($urandom_range(0, 3) != 0);
      pd = WIDTH'($urandom);
      vsync = !prev_vs && ($urandom_range(0, 9) == 0);
      prev_vs = vsync;
      tick(sb);
      checks++;
      if (fs !== exp_fs || swap !== exp_swap || we !== exp_we) begin
        failures++;
        $display("FAIL rand_pulses c%0d: fs=%b swap=%b we=%b, required %b %b %b", c, fs, swap, we, exp_fs, exp_swap, exp_we);
      end
      checks++;
      if (px_ready !== exp_ready() || done !== exp_done() || late !== CNT_BITS'(m_late)) begin
        failures++;
        $display("FAIL rand_status c%0d: rdy=%b done=%b late=%0d, required %b %b %0d",
                 c, px_ready, done, late, exp_ready(), exp_done(), m_late);
      end
      checks++;
      if ({waddr, wdata} !== exp_wr || (we === 1'b1 && {waddr, wdata} !== sb)) begin
        failures++;
        $display("FAIL rand_write c%0d: got %h, required %h (sb %h)", c, {waddr, wdata}, exp_wr, sb);
      end
      checks++;
      if ((swap && we) || (fs && prev_fs) || (swap && prev_swap)) begin
        failures++;
        $display("FAIL rand_invariant c%0d: swap=%b we=%b fs=%b prev_fs=%b prev_swap=%b, required no overlap/repeat",
                 c, swap, we, fs, prev_fs, prev_swap);
      end
      prev_fs = fs; prev_swap = swap;
    end
    vsync = 0; pv = 0;
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] sb;
    rst = 1; tick(sb); rst = 0;
    tick(sb);
    for (int i = 0; i < 5; i++) begin
      pv = 1; pd = WIDTH'(12'h010 + i); tick(sb);
    end
    checks++;
    if (waddr !== 17'd4) begin
      failures++;
      $display("FAIL midrst_progress: addr=%0d, required 4", waddr);
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      tick(sb);
      checks++;
      if (we !== 1'b0 || swap !== 1'b0 || waddr !== '0 || fs !== 1'b0) begin
        failures++;
        $display("FAIL midrst_hold%0d: we=%b swap=%b addr=%0d fs=%b, required all 0", i, we, swap, waddr, fs);
      end
    end
    rst = 0; pd = 12'h055;
    tick(sb);
    checks++;
    if (fs !== 1'b1 || we !== 1'b0 || swap !== 1'b0) begin
      failures++;
      $display("FAIL midrst_restart: fs=%b we=%b swap=%b, required 1 0 0", fs, we, swap);
    end
    tick(sb);
    checks++;
    if (we !== 1'b1 || waddr !== '0 || wdata !== 12'h055 || swap !== 1'b0 || {waddr, wdata} !== sb) begin
      failures++;
      $display("FAIL midrst_first_write: we=%b addr=%0d data=%h swap=%b, required 1 0 055 0", we, waddr, wdata, swap);
    end
    pv = 0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_vsync_swap();
    test_backpressure();
    test_late_vsync();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
